bcd_operand_entry: RTL and testbench



---
 rtl/bcd_operand_entry.sv | 132 +++++++++++++
 tb/tb_bcd_operand_entry.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry.sv
// Keypad front end for the 2-digit BCD add/sub stage: builds A, operator, B, then issues.
// Optional BCD_ENTRY_OVF_LOCK_EN: reject digits once an operand is full instead of shifting.
module bcd_operand_entry #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic                key_ready,
    output logic [4*DIGITS-1:0] op_a,
    output logic [4*DIGITS-1:0] op_b,
    output logic                sub,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [4*DIGITS-1:0] disp,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
`ifdef BCD_ENTRY_OVF_LOCK_EN
    localparam bit OVF_LOCK = 1'b1;
`else
    localparam bit OVF_LOCK = 1'b0;
`endif

    typedef enum logic [1:0] {ENTER_A, ENTER_B, ISSUE} state_t;

    state_t          state;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [CW-1:0]   cnt;
    logic            consume;
    logic            is_digit;
    logic            full;
    logic [CW-1:0]   cnt_inc;

    assign consume  = key_valid && key_ready;
    assign is_digit = (key_code <= 4'd9);
    assign full     = (cnt == CW'(DIGITS));
    assign cnt_inc  = full ? cnt : cnt + 1'b1;

    assign op_a = a;
    assign op_b = b;
    assign disp = (state == ENTER_A) ? a : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTER_A;
            a         <= '0;
            b         <= '0;
            cnt       <= '0;
            sub       <= 1'b0;
            op_valid  <= 1'b0;
            err       <= 1'b0;
            key_ready <= 1'b1;
        end else begin
            case (state)
                ENTER_A: if (consume) begin
                    if (is_digit) begin
                        if (OVF_LOCK && full) err <= 1'b1;
                        else begin
                            a   <= {a[W-5:0], key_code};
                            cnt <= cnt_inc;
                        end
                    end else begin
                        case (key_code)
                            4'd10, 4'd11: begin
                                sub   <= key_code[0];
                                b     <= '0;
                                cnt   <= '0;
                                state <= ENTER_B;
                            end
                            4'd13: begin
                                a   <= '0;
                                b   <= '0;
                                sub <= 1'b0;
                                cnt <= '0;
                                err <= 1'b0;
                            end
                            default: err <= 1'b1;   // '=' with no operator, or reserved code
                        endcase
                    end
                end
                ENTER_B: if (consume) begin
                    if (is_digit) begin
                        if (OVF_LOCK && full) err <= 1'b1;
                        else begin
                            b   <= {b[W-5:0], key_code};
                            cnt <= cnt_inc;
                        end
                    end else begin
                        case (key_code)
                            // Operator may be changed only before any B digit is typed
                            4'd10, 4'd11: begin
                                if (cnt == '0) sub <= key_code[0];
                                else           err <= 1'b1;
                            end
                            4'd12: begin
                                op_valid  <= 1'b1;
                                key_ready <= 1'b0;
                                state     <= ISSUE;
                            end
                            4'd13: begin
                                a     <= '0;
                                b     <= '0;
                                sub   <= 1'b0;
                                cnt   <= '0;
                                err   <= 1'b0;
                                state <= ENTER_A;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ISSUE: if (op_valid && op_ready) begin
                    op_valid  <= 1'b0;
                    a         <= '0;
                    b         <= '0;
                    sub       <= 1'b0;
                    cnt       <= '0;
                    key_ready <= 1'b1;
                    state     <= ENTER_A;
                end
                default: begin
                    state     <= ENTER_A;
                    key_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed-vector bench for bcd_operand_entry; expected values are hand-computed per key sequence.
module tb_bcd_operand_entry;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       sub;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] disp;
    logic       err;

    int total = 0;
    int bad   = 0;
    bit ov_seen;

    bcd_operand_entry #(.DIGITS(2)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .op_a(op_a), .op_b(op_b), .sub(sub),
        .op_valid(op_valid), .op_ready(op_ready), .disp(disp), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (op_valid) ov_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one key for one cycle; waits (bounded) for key_ready first.
    task automatic press(input logic [3:0] c);
        int n = 0;
        while (!key_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) chk("press_timeout", 32'(key_ready), 32'd1);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic handshake();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; op_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_op_a", 32'(op_a), 32'h0);
        chk("rst_op_b", 32'(op_b), 32'h0);
        chk("rst_sub", 32'(sub), 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_disp", 32'(disp), 32'h0);
        chk("rst_kready", 32'(key_ready), 32'd1);

        // Add with hold
        press(4); press(7);
        chk("t1_disp_a", 32'(disp), 32'h47);
        press(10);
        chk("t1_disp_b0", 32'(disp), 32'h00);
        press(2); press(5);
        chk("t1_disp_b", 32'(disp), 32'h25);
        press(12);
        chk("t1_valid", 32'(op_valid), 32'd1);
        chk("t1_op_a", 32'(op_a), 32'h47);
        chk("t1_op_b", 32'(op_b), 32'h25);
        chk("t1_sub", 32'(sub), 32'd0);
        chk("t1_kready", 32'(key_ready), 32'd0);
        key_valid = 1'b1; key_code = 4'd9;   // offered but must not be consumed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_hold_valid", 32'(op_valid), 32'd1);
            chk("t1_hold_ops", {16'h0, op_a, op_b}, 32'h4725);
            chk("t1_hold_kready", 32'(key_ready), 32'd0);
        end
        key_valid = 1'b0;
        handshake();
        chk("t1_post_valid", 32'(op_valid), 32'd0);
        chk("t1_post_disp", 32'(disp), 32'h00);
        chk("t1_post_kready", 32'(key_ready), 32'd1);
        chk("t1_post_op_a", 32'(op_a), 32'h00);

        // Operator override and error
        press(9); press(10); press(11); press(3); press(12);
        chk("t2_ops", {16'h0, op_a, op_b}, 32'h0903);
        chk("t2_sub", 32'(sub), 32'd1);
        chk("t2_err", 32'(err), 32'd0);
        handshake();
        press(1); press(11); press(2); press(10);
        chk("t2_late_op_err", 32'(err), 32'd1);
        chk("t2_late_op_sub", 32'(sub), 32'd1);
        chk("t2_late_op_b", 32'(disp), 32'h02);
        press(13);
        chk("t2_clr_err", 32'(err), 32'd0);
        chk("t2_clr_disp", 32'(disp), 32'h00);

        // Overflow in ENTER_A
        press(1); press(2); press(3);
`ifdef BCD_ENTRY_OVF_LOCK_EN
        chk("t3_ovf_disp", 32'(disp), 32'h12);
        chk("t3_ovf_err", 32'(err), 32'd1);
`else
        chk("t3_ovf_disp", 32'(disp), 32'h23);
        chk("t3_ovf_err", 32'(err), 32'd0);
`endif
        press(13);

        // Illegal keys
        press(12);
        chk("t4_eq_in_a_err", 32'(err), 32'd1);
        chk("t4_eq_in_a_disp", 32'(disp), 32'h00);
        chk("t4_eq_in_a_valid", 32'(op_valid), 32'd0);
        press(6); press(10); press(15);
        chk("t4_rsv_err", 32'(err), 32'd1);
        chk("t4_rsv_b", 32'(disp), 32'h00);
        press(4); press(12);
        chk("t4_ops", {16'h0, op_a, op_b}, 32'h0604);
        chk("t4_sub", 32'(sub), 32'd0);
        chk("t4_err_sticky", 32'(err), 32'd1);
        handshake();
        chk("t4_err_after_hs", 32'(err), 32'd1);
        press(13);

        // Clear mid-B
        ov_seen = 1'b0;
        press(5); press(10); press(8);
        chk("t5_b", 32'(disp), 32'h08);
        press(13);
        chk("t5_disp", 32'(disp), 32'h00);
        chk("t5_op_a", 32'(op_a), 32'h00);
        chk("t5_sub", 32'(sub), 32'd0);
        chk("t5_kready", 32'(key_ready), 32'd1);
        press(3);
        chk("t5_in_a", {16'h0, op_a, op_b}, 32'h0300);
        chk("t5_never_valid", 32'(ov_seen), 32'd0);
        press(13);

        // Reset mid-ISSUE
        press(4); press(7); press(10); press(2); press(5); press(12);
        chk("t6_valid", 32'(op_valid), 32'd1);
        chk("t6_op_a", 32'(op_a), 32'h47);
        rst = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; op_ready = 1'b0;
        chk("t6_valid_rst", 32'(op_valid), 32'd0);
        chk("t6_outs_rst", {15'h0, op_a, op_b, sub}, 32'h0);
        chk("t6_err_disp", {23'h0, err, disp}, 32'h0);
        chk("t6_kready", 32'(key_ready), 32'd1);
        press(9);
        chk("t6_enter_a", 32'(disp), 32'h09);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
